// File: rtl/imem_stream_loader_if.sv
// imem_stream_loader_if
//   Bundles the load stream, status and fetch signals of imem_stream_loader.
//   master : boot source / CPU side (drives load_* inputs and fetch_addr)
//   slave  : the loader itself (drives load_ready/done/count/overflow,
//            cpu_hold, fetch_data, fetch_fault)
//   Optional macro IMEM_LOADER_CHECKSUM_EN adds load_checksum (slave output).
interface imem_stream_loader_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              load_start;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              load_ready;
    logic              load_done;
    logic [CW-1:0]     load_count;
    logic              load_overflow;
    logic              cpu_hold;
    logic [ADDR_W-1:0] fetch_addr;
    logic [DATA_W-1:0] fetch_data;
    logic              fetch_fault;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] load_checksum;

    modport master (
        output load_start, load_valid, load_data, load_last, fetch_addr,
        input  load_ready, load_done, load_count, load_overflow, cpu_hold,
               fetch_data, fetch_fault, load_checksum
    );
    modport slave (
        input  load_start, load_valid, load_data, load_last, fetch_addr,
        output load_ready, load_done, load_count, load_overflow, cpu_hold,
               fetch_data, fetch_fault, load_checksum
    );
`else
    modport master (
        output load_start, load_valid, load_data, load_last, fetch_addr,
        input  load_ready, load_done, load_count, load_overflow, cpu_hold,
               fetch_data, fetch_fault
    );
    modport slave (
        input  load_start, load_valid, load_data, load_last, fetch_addr,
        output load_ready, load_done, load_count, load_overflow, cpu_hold,
               fetch_data, fetch_fault
    );
`endif
endinterface

// File: rtl/imem_stream_loader.sv
// imem_stream_loader
//   Instruction memory filled by a valid/ready word stream into consecutive
//   slots from 0; holds the CPU in reset until the session completes, then
//   serves zero-latency fetches by byte address.
//   Ports:
//     clk  - rising-edge clock
//     rst  - synchronous reset, active-low
//     bus  - imem_stream_loader_if.slave (load stream, status, fetch)
//   Optional macro IMEM_LOADER_CHECKSUM_EN: adds bus.load_checksum, the
//   modulo-2^DATA_W sum of all stored words of the current session.
module imem_stream_loader #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 32
) (
    input logic                clk,
    input logic                rst,
    imem_stream_loader_if.slave bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN} state_t;

    state_t            state_q, state_d;
    logic              load_ready_q, load_ready_d;
    logic              load_done_q, load_done_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              load_overflow_q, load_overflow_d;
    logic [CW-1:0]     load_count_q, load_count_d;
    logic              wr_en;
    logic              accept;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] load_checksum_q, load_checksum_d;
`endif

    logic [DATA_W-1:0] mem [DEPTH];

    always_comb begin
        state_d         = state_q;
        load_done_d     = load_done_q;
        cpu_hold_d      = cpu_hold_q;
        load_overflow_d = load_overflow_q;
        load_count_d    = load_count_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        load_checksum_d = load_checksum_q;
`endif
        wr_en  = 1'b0;
        // load_start has priority over any beat presented in the same cycle
        accept = load_ready_q && bus.load_valid && !bus.load_start;

        if (bus.load_start) begin
            state_d         = ST_LOAD;
            load_count_d    = '0;
            load_overflow_d = 1'b0;
            load_done_d     = 1'b0;
            cpu_hold_d      = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            load_checksum_d = '0;
`endif
        end else if (accept) begin
            if (load_count_q == DEPTH_C) begin
                // memory full: beat consumed but discarded
                load_overflow_d = 1'b1;
            end else begin
                wr_en        = 1'b1;
                load_count_d = load_count_q + CW'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
                load_checksum_d = load_checksum_q + bus.load_data;
`endif
            end
            if (bus.load_last) begin
                state_d     = ST_RUN;
                load_done_d = 1'b1;
                cpu_hold_d  = 1'b0;
            end
        end
        load_ready_d = (state_d == ST_LOAD);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= ST_IDLE;
            load_ready_q    <= 1'b0;
            load_done_q     <= 1'b0;
            cpu_hold_q      <= 1'b1;
            load_overflow_q <= 1'b0;
            load_count_q    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            load_checksum_q <= '0;
`endif
        end else begin
            state_q         <= state_d;
            load_ready_q    <= load_ready_d;
            load_done_q     <= load_done_d;
            cpu_hold_q      <= cpu_hold_d;
            load_overflow_q <= load_overflow_d;
            load_count_q    <= load_count_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            load_checksum_q <= load_checksum_d;
`endif
        end
    end

    // Storage is never cleared; load_count alone bounds what is reachable.
    always_ff @(posedge clk) begin
        if (rst && wr_en) begin
            mem[load_count_q[IW-1:0]] <= bus.load_data;
        end
    end

    logic [IW-1:0] f_idx;
    logic          f_fault;

    always_comb begin
        f_idx   = bus.fetch_addr[IW+1:2];
        f_fault = (|bus.fetch_addr[1:0])
                | (|bus.fetch_addr[ADDR_W-1:IW+2])
                | ({1'b0, f_idx} >= load_count_q);
    end

    assign bus.load_ready    = load_ready_q;
    assign bus.load_done     = load_done_q;
    assign bus.cpu_hold      = cpu_hold_q;
    assign bus.load_overflow = load_overflow_q;
    assign bus.load_count    = load_count_q;
    assign bus.fetch_fault   = f_fault;
    assign bus.fetch_data    = f_fault ? '0 : mem[f_idx];
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign bus.load_checksum = load_checksum_q;
`endif

endmodule

// File: tb/tb_imem_stream_loader.sv
// tb_imem_stream_loader
//   Directed, table-driven bench for imem_stream_loader: a DEPTH=64 instance
//   for load/fetch/restart/reset behaviour and a DEPTH=4 instance for
//   overflow. Define IMEM_LOADER_CHECKSUM_EN to also check load_checksum.
module tb_imem_stream_loader;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imem_stream_loader_if #(.DATA_W(32), .DEPTH(64), .ADDR_W(32)) b64 ();
    imem_stream_loader_if #(.DATA_W(32), .DEPTH(4),  .ADDR_W(32)) b4 ();

    imem_stream_loader #(.DATA_W(32), .DEPTH(64), .ADDR_W(32)) dut64 (
        .clk(clk), .rst(rst), .bus(b64.slave)
    );
    imem_stream_loader #(.DATA_W(32), .DEPTH(4), .ADDR_W(32)) dut4 (
        .clk(clk), .rst(rst), .bus(b4.slave)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        start;
        logic        valid;
        logic [31:0] data;
        logic        last;
        logic        e_ready;
        logic [6:0]  e_count;
        logic        e_done;
        logic        e_hold;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic s, input logic v, input logic [31:0] d, input logic l,
                       input logic er, input logic [6:0] ec, input logic ed, input logic eh);
        vec_t x;
        x.start = s; x.valid = v; x.data = d; x.last = l;
        x.e_ready = er; x.e_count = ec; x.e_done = ed; x.e_hold = eh;
        vt.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv64(input logic s, input logic v, input logic [31:0] d, input logic l);
        b64.load_start = s; b64.load_valid = v; b64.load_data = d; b64.load_last = l;
    endtask

    task automatic drv4(input logic s, input logic v, input logic [31:0] d, input logic l);
        b4.load_start = s; b4.load_valid = v; b4.load_data = d; b4.load_last = l;
    endtask

    task automatic fetch64(input string name, input logic [31:0] a,
                           input logic [31:0] ed, input logic ef);
        b64.fetch_addr = a;
        #1;
        chk({name, "_data"}, 64'(b64.fetch_data), 64'(ed));
        chk({name, "_fault"}, 64'(b64.fetch_fault), 64'(ef));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        drv64(0, 0, '0, 0);
        drv4(0, 0, '0, 0);
        b64.fetch_addr = '0;
        b4.fetch_addr  = '0;
        step();
        step();

        // reset state
        chk("rst_ready", 64'(b64.load_ready), 64'd0);
        chk("rst_done",  64'(b64.load_done),  64'd0);
        chk("rst_count", 64'(b64.load_count), 64'd0);
        chk("rst_ovf",   64'(b64.load_overflow), 64'd0);
        chk("rst_hold",  64'(b64.cpu_hold),   64'd1);
        fetch64("rst_fetch0", 32'd0, 32'd0, 1'b1);
        rst = 1'b1;

        // basic load of 6 words
        add(1, 0, 32'h0,        0, 1, 0, 0, 1);
        add(0, 1, 32'h00021020, 0, 1, 1, 0, 1);
        add(0, 1, 32'h00844022, 0, 1, 2, 0, 1);
        add(0, 1, 32'h00a63825, 0, 1, 3, 0, 1);
        add(0, 1, 32'hac09000c, 0, 1, 4, 0, 1);
        add(0, 1, 32'h8c0d000c, 0, 1, 5, 0, 1);
        add(0, 1, 32'h10000000, 1, 0, 6, 1, 0);
        for (int unsigned i = 0; i < vt.size(); i++) begin
            drv64(vt[i].start, vt[i].valid, vt[i].data, vt[i].last);
            step();
            chk($sformatf("basic%0d_ready", i), 64'(b64.load_ready), 64'(vt[i].e_ready));
            chk($sformatf("basic%0d_count", i), 64'(b64.load_count), 64'(vt[i].e_count));
            chk($sformatf("basic%0d_done",  i), 64'(b64.load_done),  64'(vt[i].e_done));
            chk($sformatf("basic%0d_hold",  i), 64'(b64.cpu_hold),   64'(vt[i].e_hold));
        end
        drv64(0, 0, '0, 0);
        fetch64("f20", 32'd20, 32'h10000000, 1'b0);
        fetch64("f0",  32'd0,  32'h00021020, 1'b0);
        fetch64("f12", 32'd12, 32'hac09000c, 1'b0);
        fetch64("f24", 32'd24, 32'd0, 1'b1);
        fetch64("f6",  32'd6,  32'd0, 1'b1);
        fetch64("fhi", 32'h40000000, 32'd0, 1'b1);

        // restart from RUN, then gapped stream (last=1 on invalid cycles is ignored);
        // then restart inside LOAD colliding with a last beat
        vt.delete();
        add(1, 0, 32'h0,        0, 1, 0, 0, 1);
        add(0, 1, 32'h11111111, 0, 1, 1, 0, 1);
        add(0, 0, 32'hdeadbeef, 1, 1, 1, 0, 1);
        add(0, 1, 32'h22222222, 0, 1, 2, 0, 1);
        add(0, 0, 32'hdeadbeef, 1, 1, 2, 0, 1);
        add(0, 1, 32'h33333333, 0, 1, 3, 0, 1);
        add(0, 0, 32'hdeadbeef, 1, 1, 3, 0, 1);
        add(0, 1, 32'h44444444, 1, 0, 4, 1, 0);
        add(0, 1, 32'h55555555, 1, 0, 4, 1, 0);
        add(1, 0, 32'h0,        0, 1, 0, 0, 1);
        add(0, 1, 32'haaaaaaaa, 0, 1, 1, 0, 1);
        add(1, 1, 32'hbbbbbbbb, 1, 1, 0, 0, 1);
        add(0, 1, 32'hcccccccc, 1, 0, 1, 1, 0);
        for (int unsigned i = 0; i < vt.size(); i++) begin
            drv64(vt[i].start, vt[i].valid, vt[i].data, vt[i].last);
            step();
            chk($sformatf("seq%0d_ready", i), 64'(b64.load_ready), 64'(vt[i].e_ready));
            chk($sformatf("seq%0d_count", i), 64'(b64.load_count), 64'(vt[i].e_count));
            chk($sformatf("seq%0d_done",  i), 64'(b64.load_done),  64'(vt[i].e_done));
            chk($sformatf("seq%0d_hold",  i), 64'(b64.cpu_hold),   64'(vt[i].e_hold));
        end
        drv64(0, 0, '0, 0);
        fetch64("rs_f0", 32'd0, 32'hcccccccc, 1'b0);
        fetch64("rs_f4", 32'd4, 32'd0, 1'b1);

        // reset mid-session after two beats
        drv64(1, 0, '0, 0); step();
        drv64(0, 1, 32'h01010101, 0); step();
        drv64(0, 1, 32'h02020202, 0); step();
        chk("mid_count_pre", 64'(b64.load_count), 64'd2);
        drv64(0, 0, '0, 0);
        rst = 1'b0; step();
        chk("mid_ready", 64'(b64.load_ready), 64'd0);
        chk("mid_count", 64'(b64.load_count), 64'd0);
        chk("mid_hold",  64'(b64.cpu_hold),   64'd1);
        chk("mid_done",  64'(b64.load_done),  64'd0);
        rst = 1'b1;
        fetch64("mid_f0", 32'd0, 32'd0, 1'b1);
        step();
        chk("mid_idle_ready", 64'(b64.load_ready), 64'd0);

        // overflow on the DEPTH=4 instance
        drv4(1, 0, '0, 0); step();
        for (int unsigned i = 1; i <= 6; i++) begin
            drv4(0, 1, 32'(i), (i == 6) ? 1'b1 : 1'b0);
            step();
            if (i == 4) begin
                chk("ovf_c4_count", 64'(b4.load_count), 64'd4);
                chk("ovf_c4_flag",  64'(b4.load_overflow), 64'd0);
                chk("ovf_c4_ready", 64'(b4.load_ready), 64'd1);
            end
            if (i == 5) chk("ovf_c5_flag", 64'(b4.load_overflow), 64'd1);
        end
        drv4(0, 0, '0, 0);
        chk("ovf_count", 64'(b4.load_count), 64'd4);
        chk("ovf_flag",  64'(b4.load_overflow), 64'd1);
        chk("ovf_done",  64'(b4.load_done), 64'd1);
        chk("ovf_hold",  64'(b4.cpu_hold), 64'd0);
        b4.fetch_addr = 32'd12; #1;
        chk("ovf_mem3",  64'(b4.fetch_data), 64'd4);
        chk("ovf_mem3_fault", 64'(b4.fetch_fault), 64'd0);
        b4.fetch_addr = 32'd16; #1;
        chk("ovf_f16_fault", 64'(b4.fetch_fault), 64'd1);
        chk("ovf_f16_data",  64'(b4.fetch_data), 64'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk("ovf_csum", 64'(b4.load_checksum), 64'd10);
`endif
        drv4(1, 0, '0, 0); step();
        drv4(0, 0, '0, 0);
        chk("ovf_clear", 64'(b4.load_overflow), 64'd0);
        chk("ovf_clear_count", 64'(b4.load_count), 64'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        drv64(1, 0, '0, 0); step();
        chk("csum_clear", 64'(b64.load_checksum), 64'd0);
        drv64(0, 1, 32'hffffffff, 0); step();
        drv64(0, 1, 32'h00000002, 1); step();
        drv64(0, 0, '0, 0);
        chk("csum_done", 64'(b64.load_done), 64'd1);
        chk("csum_val",  64'(b64.load_checksum), 64'h1);
        drv64(0, 1, 32'h12345678, 1); step();
        drv64(0, 0, '0, 0);
        chk("csum_hold", 64'(b64.load_checksum), 64'h1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/imem_stream_loader.md
Name: imem_stream_loader

Overview:
- Parametrised instruction-memory block with a streaming load port; successor to the single-word address/data initialise path into the CPU.
- A valid/ready word stream is written into consecutive word slots starting at 0, with no per-word address supplied.
- The block holds the CPU in reset until loading finishes, then serves combinational instruction fetches by byte address.
- Sits between the bench/boot source and the CPU fetch stage.

Parameters:
- DATA_W, 32, instruction word width in bits.
- DEPTH, 64, number of instruction words; power of two, at least 4.
- ADDR_W, 32, fetch byte-address width.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous reset, active-low.
- load_start  in  1  single-cycle pulse that begins a new load session.
- load_valid  in  1  load_data is valid this cycle.
- load_data  in  DATA_W  instruction word.
- load_last  in  1  marks the final word of a session; sampled only with an accepted beat.
- load_ready  out  1  block accepts a beat this cycle.
- load_done  out  1  session complete; memory is valid.
- load_count  out  $clog2(DEPTH)+1  number of words stored in the current session.
- load_overflow  out  1  sticky: a beat arrived after DEPTH words were stored.
- cpu_hold  out  1  active-high reset request to the CPU.
- fetch_addr  in  ADDR_W  fetch byte address.
- fetch_data  out  DATA_W  instruction at fetch_addr.
- fetch_fault  out  1  fetch_addr is misaligned or at/after word load_count.

Behaviour:
- Reset (rst=0 at an edge): state=IDLE, load_ready=0, load_done=0, load_count=0, load_overflow=0, cpu_hold=1. Memory array contents are not cleared.
- FSM states: IDLE, LOAD, RUN.
- IDLE -> LOAD on load_start. In the same edge: load_count=0, load_overflow=0, load_done=0, cpu_hold=1.
- LOAD: load_ready=1.
  - A beat is accepted when load_valid & load_ready. The word is written to mem[load_count] and load_count increments by 1.
  - When load_count==DEPTH, beats are still accepted (ready stays 1) but are discarded, and load_overflow is set.
  - An accepted beat with load_last=1 moves to RUN on that edge. The last word is stored if there is room.
- RUN: load_ready=0, load_done=1, cpu_hold=0.
  - load_start returns to LOAD with cpu_hold=1 asserted on the same edge.
- load_start while in LOAD restarts the session: count cleared, overflow cleared, and any beat in that cycle is ignored.
- load_start coincident with an accepted load_last beat: load_start wins; the beat is ignored.
- Fetch is combinational with zero latency.
  - Word index = fetch_addr[$clog2(DEPTH)+1:2].
  - fetch_fault=1 if fetch_addr[1:0]!=0, or if fetch_addr>>2 >= load_count, or if any upper address bits beyond the index are nonzero.
  - On a fault, fetch_data=0 (NOP). Otherwise fetch_data=mem[index].
  - Fetch is valid in every state. In IDLE after reset, load_count=0, so every fetch faults.
- load_count saturates at DEPTH and never wraps.
- Reset asserted mid-session aborts it: state returns to IDLE, and the words already written stay in memory but are unreachable because load_count=0.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- When defined, the block adds an output port load_checksum (DATA_W bits).
  - Cleared to 0 on reset and on load_start.
  - On every stored beat (overflow beats excluded): checksum = checksum + load_data, modulo 2^DATA_W.
  - Holds its value in RUN.
- When undefined, the port and the adder are absent and all other behaviour is identical.

Test Plan:
- Basic load:
  - Stimulus: reset, load_start, stream 6 words 0x00021020, 0x00844022, 0x00a63825, 0xac09000c, 0x8c0d000c, 0x10000000 with load_last on the 6th.
  - Required: load_done=1, load_count=6, cpu_hold=0 on the following cycle.
  - Required: fetch_addr=20 returns 0x10000000; fetch_addr=24 gives fetch_fault=1 and data 0.
- Backpressure-free gaps:
  - Stimulus: toggle load_valid 1/0 every cycle over 4 words.
  - Required: load_count increments only on valid cycles; the final count is 4.
- Overflow:
  - Stimulus: DEPTH=4, stream 6 words with last on the 6th.
  - Required: load_count=4, load_overflow=1, done=1; mem[3] holds the 4th word.
- Misaligned fetch:
  - Stimulus: after a basic load, fetch_addr=6.
  - Required: fetch_fault=1, fetch_data=0.
- Restart and reset mid-session:
  - Stimulus: load_start again in RUN.
  - Required: cpu_hold=1 and load_count=0 at the next edge.
  - Stimulus: after 2 beats, apply rst=0 for one cycle.
  - Required: state IDLE, load_count=0, cpu_hold=1.
- Checksum (macro defined):
  - Stimulus: stream words 0xFFFFFFFF and 0x00000002.
  - Required: load_checksum=0x00000001 at done.
